// File: rtl/clkscale_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : clkscale_arbiter
// Purpose  : Divides CCLK down to a slow clock/tick and lets NREQ requesters
//            change the half-period through a round-robin arbiter. A granted
//            value is staged and only applied when clk falls, so the output
//            never carries a runt pulse.
// Ports    : CCLK      - system clock, all logic on the rising edge
//            rst       - asynchronous active-high reset
//            req       - per-requester request level (held until granted)
//            req_scale - requested half-periods, requester i at [i*W +: W]
//            grant     - one-hot, one-cycle grant pulse
//            busy      - a new scale is staged, waiting for the clk fall
//            clkscale  - half-period currently in effect
//            clk       - divided clock
//            tick      - one-cycle pulse on every clk toggle
// Revision : 1.0 - initial release
// ============================================================================
module clkscale_arbiter #(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned W             = 32,
  parameter int unsigned DEFAULT_SCALE = 25000000
) (
  input  logic              CCLK,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_scale,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [W-1:0]      clkscale,
  output logic              clk,
  output logic              tick
);

  localparam int unsigned    c_PW            = $clog2(NREQ);
  localparam logic [W-1:0]   c_DEFAULT_SCALE = W'(DEFAULT_SCALE);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [W-1:0]      r_clkq;
  logic              r_clk;
  logic              r_tick;
  logic [NREQ-1:0]   r_grant;
  logic              r_busy;
  logic [W-1:0]      r_clkscale;
  logic [W-1:0]      r_staged;
  logic [c_PW-1:0]   r_ptr;

  logic [W-1:0]      w_eff;
  logic              w_tc;
  logic              w_apply;
  logic              w_found;
  logic [c_PW-1:0]   w_win;
  int                w_cand;
  logic [W-1:0]      w_win_scale;
  logic [c_PW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0]   w_grant_nxt;
  logic              w_busy_nxt;
  logic              w_take;

  // A scale of zero behaves as one so the divider can never stall.
  assign w_eff = (r_clkscale == '0) ? W'(1) : r_clkscale;

  // Compare in W+1 bits so clkq+1 cannot wrap around at all-ones.
  assign w_tc = ({1'b0, r_clkq} + (W+1)'(1)) >= {1'b0, w_eff};

  // The staged scale is only taken on the terminal count that drops clk.
  assign w_apply = (r_state == S_WAIT) && w_tc && r_clk;

  // Round-robin search: first set request at or above r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      w_cand = int'(r_ptr) + k;
      if (w_cand >= int'(NREQ)) begin
        w_cand = w_cand - int'(NREQ);
      end
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = c_PW'(w_cand);
      end
    end
  end

  assign w_win_scale = req_scale[int'(w_win)*int'(W) +: W];
  assign w_ptr_nxt   = (w_win == c_PW'(NREQ-1)) ? '0 : w_win + c_PW'(1);

  // Next-state and registered-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = '0;
    w_busy_nxt  = r_busy;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_take      = 1'b1;
          w_grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
          // Re-requesting the scale already in effect needs no staging.
          if (w_win_scale != r_clkscale) begin
            w_state_nxt = S_WAIT;
            w_busy_nxt  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (w_apply) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CCLK or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CCLK or posedge rst) begin
    if (rst) begin
      r_clkq     <= '0;
      r_clk      <= 1'b0;
      r_tick     <= 1'b0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_clkscale <= c_DEFAULT_SCALE;
      r_staged   <= '0;
      r_ptr      <= '0;
    end else begin
      r_tick  <= w_tc;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
      // An apply edge is always a 1->0 toggle, so the normal toggle path
      // already drives clk low and clears the counter.
      if (w_tc) begin
        r_clkq <= '0;
        r_clk  <= ~r_clk;
      end else begin
        r_clkq <= r_clkq + W'(1);
      end
      if (w_apply) begin
        r_clkscale <= r_staged;
      end
      if (w_take) begin
        r_staged <= w_win_scale;
        r_ptr    <= w_ptr_nxt;
      end
    end
  end

  assign grant    = r_grant;
  assign busy     = r_busy;
  assign clkscale = r_clkscale;
  assign clk      = r_clk;
  assign tick     = r_tick;

endmodule
`default_nettype wire
